// File: rtl/mem_resp_pkg.sv
// Shared definitions for the data-memory responder: ISA width, base address,
// access-size codes used by the execute unit, and FSM state encodings.
package mem_resp_pkg;

  localparam int                   ISA_WIDTH = 32;
  localparam logic [ISA_WIDTH-1:0] BASE_ADDR = 32'h8000_0000;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Unshifted byte-lane mask for an access size; the reserved code acts as word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: size_mask = 4'b0001;
      MEM_SIZE_H: size_mask = 4'b0011;
      default:    size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Request/response bundle between the execute unit (master) and mem_resp (slave).
interface mem_resp_if;
  import mem_resp_pkg::*;

  logic [ISA_WIDTH-1:0] mem_addr;
  logic [ISA_WIDTH-1:0] mem_w;
  logic [1:0]           mem_size;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic                 req_ready;
  logic [ISA_WIDTH-1:0] mem_r;
  logic                 resp_valid;
  logic                 mem_fault;

  modport master (
    output mem_addr, mem_w, mem_size, mem_r_en, mem_w_en,
    input  req_ready, mem_r, resp_valid, mem_fault
  );

  modport slave (
    input  mem_addr, mem_w, mem_size, mem_r_en, mem_w_en,
    output req_ready, mem_r, resp_valid, mem_fault
  );

endinterface

// File: rtl/mem_resp_lane.sv
// Byte-lane alignment: shifts store data and mask into place, aligns and masks
// read data, and flags accesses that spill past the end of the word.
module mem_resp_lane
  import mem_resp_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           off,
  input  logic [ISA_WIDTH-1:0] wdata,
  input  logic [ISA_WIDTH-1:0] rword,
  output logic [ISA_WIDTH-1:0] wdata_sh,
  output logic [3:0]           wmask,
  output logic [ISA_WIDTH-1:0] rdata,
  output logic                 misalign
);

  logic [3:0]      base;
  logic [6:0]      mask_wide;
  logic [3:0][7:0] byte_keep;
  logic [ISA_WIDTH-1:0] rshift;

  assign base      = size_mask(size);
  assign mask_wide = {3'b000, base} << off;
  // Lanes pushed past byte 3 are dropped; their presence marks a misaligned access.
  assign wmask     = mask_wide[3:0];
  assign misalign  = |mask_wide[6:4];

  assign wdata_sh  = wdata << {off, 3'b000};
  assign rshift    = rword >> {off, 3'b000};

  for (genvar b = 0; b < 4; b++) begin : g_keep
    assign byte_keep[b] = {8{base[b]}};
  end

  assign rdata = rshift & byte_keep;

endmodule

// File: rtl/mem_resp.sv
// Data-memory responder: one outstanding request, fixed LATENCY, 1-cycle strobe.
// Optional MEM_RESP_FAULT_EN adds range/misalignment faults.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       rst,
  mem_resp_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [ISA_WIDTH-1:0] mem_q [DEPTH];

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 accept;
  logic [ISA_WIDTH-1:0] rel;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]           off;
  logic                 out_of_range;
  logic                 fault;

  logic [ISA_WIDTH-1:0] rd_word, wdata_sh, rdata, cur_data;
  logic [3:0]           wmask;
  logic                 misalign;

  logic [ISA_WIDTH-1:0] pend_data_q, mem_r_q;
  logic                 pend_flt_q, flt_q;
  logic                 rdy, vld;

  assign accept       = (bus.mem_r_en | bus.mem_w_en) & (state_q == ST_IDLE);
  assign rel          = bus.mem_addr - BASE_ADDR;
  assign idx          = rel[DEPTH_LOG2+1:2];
  assign off          = bus.mem_addr[1:0];
  assign out_of_range = (rel >> (DEPTH_LOG2 + 2)) != '0;
  assign rd_word      = mem_q[idx];

  mem_resp_lane u_lane (
    .size     (bus.mem_size),
    .off      (off),
    .wdata    (bus.mem_w),
    .rword    (rd_word),
    .wdata_sh (wdata_sh),
    .wmask    (wmask),
    .rdata    (rdata),
    .misalign (misalign)
  );

`ifdef MEM_RESP_FAULT_EN
  assign fault = out_of_range | misalign;
`else
  // Without fault checking, out-of-range wraps and misaligned lanes are simply dropped.
  logic unused_flt;
  assign unused_flt = out_of_range | misalign;
  assign fault      = 1'b0;
`endif

  assign cur_data = fault ? '0 : rdata;

  // Word array is deliberately not reset; writes commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && bus.mem_w_en && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // State register and latency counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    vld = 1'b0;
    case (state_q)
      ST_IDLE: rdy = 1'b1;
      ST_RESP: vld = 1'b1;
      default: ;
    endcase
  end

  // Pending result is captured at acceptance and only exposed on entry to RESP,
  // so mem_r keeps the previous response until the new one is due.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_data_q <= '0;
      pend_flt_q  <= 1'b0;
      mem_r_q     <= '0;
      flt_q       <= 1'b0;
    end else begin
      if (accept) begin
        pend_data_q <= cur_data;
        pend_flt_q  <= fault;
      end
      if (state_d == ST_RESP) begin
        mem_r_q <= accept ? cur_data : pend_data_q;
        flt_q   <= accept ? fault    : pend_flt_q;
      end
    end
  end

  assign bus.req_ready  = rdy;
  assign bus.resp_valid = vld;
  assign bus.mem_r      = mem_r_q;
  assign bus.mem_fault  = vld & flt_q;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp (LATENCY=2); expectations follow MEM_RESP_FAULT_EN.
module tb_mem_resp;
  import mem_resp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  mem_resp_if bus ();

  mem_resp #(.DEPTH_LOG2(12), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.mem_size = size;
    bus.mem_addr = addr;
    bus.mem_w    = data;
  endtask

  // Issue one request, check latency, strobe width, data, fault and hold.
  task automatic req(input string tag, input logic r, input logic w, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] data,
                     input bit chk_d, input logic [31:0] exp_d, input logic exp_f);
    int  n;
    bit  got;
    @(negedge clk);
    drive(r, w, size, addr, data);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid) got = 1;
    end
    chk({tag, " latency"}, n, 2);
    if (got) begin
      if (chk_d) chk({tag, " data"}, bus.mem_r, exp_d);
      chk({tag, " fault"}, {31'b0, bus.mem_fault}, {31'b0, exp_f});
      @(negedge clk);
      chk({tag, " strobe"}, {31'b0, bus.resp_valid}, 32'd0);
      if (chk_d) chk({tag, " hold"}, bus.mem_r, exp_d);
    end
  endtask

  initial begin
    int n, seen;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    #2;
    chk("reset req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("reset mem_r",      bus.mem_r,               32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Word store then load
    req("wr word", 1'b0, 1'b1, MEM_SIZE_W, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    req("rd word", 1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0004, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Reset mid-WAIT after a write; the commit must survive
    @(negedge clk);
    drive(1'b0, 1'b1, MEM_SIZE_W, 32'h8000_0010, 32'h55AA_0001);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("midrst resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("midrst mem_fault",  {31'b0, bus.mem_fault},  32'd0);
    chk("midrst mem_r",      bus.mem_r,               32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    chk("midrst dropped resp", seen, 0);
    req("rd after rst", 1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0010, 32'h0, 1'b1, 32'h55AA_0001, 1'b0);

    // Byte and half lanes; writes return pre-write data
    req("wr byte", 1'b0, 1'b1, MEM_SIZE_B, 32'h8000_0006, 32'h0000_00AB, 1'b1, 32'h0000_00AD, 1'b0);
    req("rd word2", 1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0004, 32'h0, 1'b1, 32'hDEAB_BEEF, 1'b0);
    req("rd byte", 1'b1, 1'b0, MEM_SIZE_B, 32'h8000_0007, 32'h0, 1'b1, 32'h0000_00DE, 1'b0);
    req("wr half", 1'b0, 1'b1, MEM_SIZE_H, 32'h8000_0004, 32'h0000_1234, 1'b1, 32'h0000_BEEF, 1'b0);
    req("rd word3", 1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0004, 32'h0, 1'b1, 32'hDEAB_1234, 1'b0);

    // Read and write together
    req("rw word", 1'b1, 1'b1, MEM_SIZE_W, 32'h8000_0004, 32'h1111_1111, 1'b1, 32'hDEAB_1234, 1'b0);
    req("rd rsvd size", 1'b1, 1'b0, 2'd3, 32'h8000_0004, 32'h0, 1'b1, 32'h1111_1111, 1'b0);

    // Busy ignore: second request held from right after the first acceptance
    @(negedge clk);
    drive(1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0004, 32'h0);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0010, 32'h0);
    n = 0; seen = 0;
    while (n < 20 && seen == 0) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid) seen = 1;
    end
    chk("busy A latency", n, 2);
    chk("busy A data", bus.mem_r, 32'h1111_1111);
    n = 0; seen = 0;
    while (n < 20 && seen == 0) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid) seen = 1;
      else if (bus.req_ready) begin
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      end
    end
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("busy B spacing", n, 3);
    chk("busy B data", bus.mem_r, 32'h55AA_0001);
    @(negedge clk);

    // Out-of-range and misaligned accesses
    req("wr base", 1'b0, 1'b1, MEM_SIZE_W, 32'h8000_0000, 32'h0BAD_C0DE, 1'b0, 32'h0, 1'b0);
`ifdef MEM_RESP_FAULT_EN
    req("wr oor", 1'b0, 1'b1, MEM_SIZE_W, 32'h8000_4000, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1);
    req("rd base", 1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0000, 32'h0, 1'b1, 32'h0BAD_C0DE, 1'b0);
    req("rd misalign", 1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0002, 32'h0, 1'b1, 32'h0, 1'b1);
`else
    req("wr oor", 1'b0, 1'b1, MEM_SIZE_W, 32'h8000_4000, 32'hCAFE_F00D, 1'b1, 32'h0BAD_C0DE, 1'b0);
    req("rd base", 1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0000, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
    req("rd misalign", 1'b1, 1'b0, MEM_SIZE_W, 32'h8000_0002, 32'h0, 1'b1, 32'h0000_CAFE, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
